// File: rtl/gear_pkg.sv
// Shared types and default parameters for the gear shifter.
package gear_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam int N_DEF        = 4;
    localparam int DEBOUNCE_DEF = 2;
    localparam int DWELL_DEF    = 3;

    // Width of a counter that must hold values 0..max.
    function automatic int cnt_w(input int max);
        return (max < 1) ? 1 : $clog2(max + 1);
    endfunction

endpackage

// File: rtl/gear_prio_enc.sv
// Combinational N-to-W highest-bit priority encoder with any-bit flag.
module gear_prio_enc #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req_i,
    output logic [W-1:0] idx_o,
    output logic         any_o
);

    always_comb begin
        idx_o = '0;
        any_o = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (req_i[i]) begin
                idx_o = W'(i);
                any_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gear_shifter.sv
// Debounced lever-to-gear controller that walks the gear one step
// at a time toward the accepted target with a fixed dwell.
module gear_shifter
    import gear_pkg::*;
#(
    parameter int N        = N_DEF,
    parameter int W        = $clog2(N),
    parameter int DEBOUNCE = DEBOUNCE_DEF,
    parameter int DWELL    = DWELL_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] req,
    output logic [W-1:0] gear,
    output logic [W-1:0] target,
    output logic         valid,
    output logic         shifting,
    output logic         up_pulse,
    output logic         dn_pulse
);

    localparam int CW = cnt_w(DEBOUNCE);
    localparam int DW = cnt_w(DWELL);
    localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE);
    localparam logic [DW-1:0] DW_MAX = DW'(DWELL);

    logic [W-1:0]  c;
    logic          any;

    logic [W-1:0]  cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          valid_q, valid_d;
    logic [W-1:0]  target_q, target_d;
    logic [W-1:0]  gear_q, gear_d;
    logic [DW-1:0] dwell_q, dwell_d;
    state_e        state_q, state_d;
    logic          up_q, up_d;
    logic          dn_q, dn_d;

    gear_prio_enc #(
        .N (N),
        .W (W)
    ) u_enc (
        .req_i (req),
        .idx_o (c),
        .any_o (any)
    );

    always_comb begin
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        valid_d  = valid_q;
        target_d = target_q;
        if (en) begin
            valid_d = any;
            if (!any) begin
                cnt_d = '0;
            end else begin
                cand_d = c;
                // A sample only extends the run if the last one was live.
                if (valid_q && c == cand_q) begin
                    if (cnt_q != DB_MAX) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    cnt_d = CW'(1);
                end
                if (cnt_d == DB_MAX && c != target_q) begin
                    target_d = c;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gear_d  = gear_q;
        dwell_d = dwell_q;
        up_d    = 1'b0;
        dn_d    = 1'b0;
        if (en) begin
            unique case (state_q)
                IDLE: begin
                    if (target_d != gear_q) begin
                        state_d = SHIFT;
                        dwell_d = '0;
                    end
                end
                SHIFT: begin
                    dwell_d = dwell_q + 1'b1;
                    if (target_q == gear_q) begin
                        state_d = IDLE;
                        dwell_d = '0;
                    end else if (dwell_d == DW_MAX) begin
                        dwell_d = '0;
                        if (target_q > gear_q) begin
                            gear_d = gear_q + 1'b1;
                            up_d   = 1'b1;
                        end else begin
                            gear_d = gear_q - 1'b1;
                            dn_d   = 1'b1;
                        end
                        if (gear_d == target_d) begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cand_q   <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            target_q <= '0;
            gear_q   <= '0;
            dwell_q  <= '0;
            state_q  <= IDLE;
            up_q     <= 1'b0;
            dn_q     <= 1'b0;
        end else begin
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            target_q <= target_d;
            gear_q   <= gear_d;
            dwell_q  <= dwell_d;
            state_q  <= state_d;
            up_q     <= up_d;
            dn_q     <= dn_d;
        end
    end

    assign gear     = gear_q;
    assign target   = target_q;
    assign valid    = valid_q;
    assign shifting = (state_q == SHIFT);
    assign up_pulse = up_q;
    assign dn_pulse = dn_q;

endmodule

// File: tb/tb_gear_shifter.sv
// Scoreboard bench for gear_shifter: directed scenarios plus random
// lever traffic checked against a cycle-level behavioural model.
module tb_gear_shifter;

    localparam int N  = 4;
    localparam int W  = 2;
    localparam int DB = 2;
    localparam int DW = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b1;
    logic [N-1:0] req = '0;
    logic [W-1:0] gear;
    logic [W-1:0] target;
    logic         valid;
    logic         shifting;
    logic         up_pulse;
    logic         dn_pulse;

    always #5 clk = ~clk;

    gear_shifter #(
        .N        (N),
        .W        (W),
        .DEBOUNCE (DB),
        .DWELL    (DW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .req      (req),
        .gear     (gear),
        .target   (target),
        .valid    (valid),
        .shifting (shifting),
        .up_pulse (up_pulse),
        .dn_pulse (dn_pulse)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_cyc    = 0;

    logic [7:0] sb_q[$];

    // Model state: plain integers, candidate history as a queue.
    int  m_gear, m_tgt, m_el;
    bit  m_valid, m_shift, m_up, m_dn;
    int  hist[$];

    logic         p_rst = 1'b1;
    logic         p_en  = 1'b1;
    logic [N-1:0] p_req = '0;

    function automatic int top_bit(input logic [N-1:0] r);
        int t;
        t = -1;
        for (int i = 0; i < N; i++)
            if (r[i]) t = i;
        return t;
    endfunction

    task automatic m_reset();
        m_gear  = 0;
        m_tgt   = 0;
        m_el    = 0;
        m_valid = 0;
        m_shift = 0;
        m_up    = 0;
        m_dn    = 0;
        hist.delete();
    endtask

    task automatic m_edge();
        int c;
        int newt;
        bit acc;
        if (p_rst) begin
            m_reset();
            return;
        end
        m_up = 0;
        m_dn = 0;
        if (!p_en) return;
        c = top_bit(p_req);
        hist.push_back(c);
        if (hist.size() > DB) hist.delete(0);
        m_valid = (c >= 0);
        acc = (c >= 0) && (hist.size() == DB) && (c != m_tgt);
        foreach (hist[i])
            if (hist[i] != c) acc = 0;
        newt = acc ? c : m_tgt;
        if (!m_shift) begin
            if (newt != m_gear) begin
                m_shift = 1;
                m_el = 0;
            end
        end else begin
            m_el++;
            if (m_tgt == m_gear) begin
                m_shift = 0;
                m_el = 0;
            end else if (m_el == DW) begin
                m_el = 0;
                if (m_tgt > m_gear) begin
                    m_gear++;
                    m_up = 1;
                end else begin
                    m_gear--;
                    m_dn = 1;
                end
                if (m_gear == newt) m_shift = 0;
            end
        end
        m_tgt = newt;
    endtask

    task automatic push_exp();
        logic [7:0] e;
        e = {W'(m_gear), W'(m_tgt), m_valid, m_shift, m_up, m_dn};
        sb_q.push_back(e);
    endtask

    // Drive inputs for the coming edge; the model first applies the
    // edge just taken, then any asynchronous reset now asserted.
    task automatic cycle(input logic [N-1:0] r, input logic e,
                         input logic rs);
        @(posedge clk);
        #2;
        m_edge();
        req = r;
        en  = e;
        rst = rs;
        p_req = r;
        p_en  = e;
        p_rst = rs;
        if (rs) m_reset();
        push_exp();
    endtask

    task automatic hold(input logic [N-1:0] r, input int n);
        for (int i = 0; i < n; i++) cycle(r, 1'b1, 1'b0);
    endtask

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [7:0] e;
        logic [7:0] a;
        n_cyc++;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            a = {gear, target, valid, shifting, up_pulse, dn_pulse};
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display({"FAIL outputs cyc %0d: got g=%0d t=%0d v=%b ",
                          "s=%b u=%b d=%b want g=%0d t=%0d v=%b s=%b ",
                          "u=%b d=%b"},
                         n_cyc, a[7:6], a[5:4], a[3], a[2], a[1], a[0],
                         e[7:6], e[5:4], e[3], e[2], e[1], e[0]);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int e;
        logic [7:0] want;
        logic [N-1:0] r;
        logic ee;
        logic rr;
        int len;
        m_reset();

        // Straight climb 0 -> 3 with absolute edge timing.
        cycle(4'b0000, 1'b1, 1'b1);
        cycle(4'b1000, 1'b1, 1'b0);
        for (int k = 2; k <= 13; k++) begin
            cycle(4'b1000, 1'b1, 1'b0);
            e = k - 1;
            want[7:6] = (e >= 11) ? 2'd3 : (e >= 8) ? 2'd2 :
                        (e >= 5) ? 2'd1 : 2'd0;
            want[5:4] = (e >= 2) ? 2'd3 : 2'd0;
            want[3]   = 1'b1;
            want[2]   = (e >= 2 && e <= 10);
            want[1]   = (e == 5 || e == 8 || e == 11);
            want[0]   = 1'b0;
            chk($sformatf("climb_edge%0d", e),
                {gear, target, valid, shifting, up_pulse, dn_pulse},
                want);
        end

        // Two-bit request picks the higher gear.
        cycle(4'b0000, 1'b1, 1'b1);
        hold(4'b0101, 12);

        // Single-sample glitch must not move the target.
        cycle(4'b0000, 1'b1, 1'b1);
        hold(4'b0001, 3);
        hold(4'b0100, 1);
        hold(4'b0001, 4);
        chk("glitch_target", {6'd0, target}, 8'd0);

        // Mid-shift reversal back to gear 0.
        cycle(4'b0000, 1'b1, 1'b1);
        hold(4'b1000, 5);
        hold(4'b0001, 10);

        // Request dropped at gear 2.
        cycle(4'b0000, 1'b1, 1'b1);
        hold(4'b0100, 10);
        hold(4'b0000, 8);
        chk("drop_hold", {4'd0, gear, target}, 8'b0000_1010);

        // Enable freeze mid-shift, then resume on remaining dwell.
        cycle(4'b0000, 1'b1, 1'b1);
        hold(4'b1000, 6);
        for (int i = 0; i < 5; i++) cycle(4'b1000, 1'b0, 1'b0);
        hold(4'b1000, 2);
        chk("freeze_edge12", {6'd0, gear}, 8'd1);
        hold(4'b1000, 1);
        chk("freeze_edge13", {5'd0, gear, up_pulse}, 8'b101);
        hold(4'b1000, 2);
        cycle(4'b1000, 1'b1, 1'b1);
        #1;
        chk("async_rst", {3'd0, gear, target, shifting}, 8'd0);
        hold(4'b0010, 10);

        // Random lever traffic.
        for (int s = 0; s < 300; s++) begin
            r   = N'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) r = '0;
            len = $urandom_range(1, 9);
            for (int i = 0; i < len; i++) begin
                ee = ($urandom_range(0, 9) != 0);
                rr = ($urandom_range(0, 99) < 2);
                cycle(r, ee, rr);
            end
        end
        cycle(4'b0000, 1'b1, 1'b0);

        @(negedge clk);
        #1;
        chk("sb_drained", 8'(sb_q.size()), 8'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
